// File: rtl/micro_sequencer.sv
// Microprogram sequencer driving the CodeROM address: uPC, return stack,
// loop counter and a selectable condition mux, one address per clock.
module micro_sequencer #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  parameter int SEL_W       = 3,
  parameter int CNT_W       = 8,
  localparam int COND_W     = 2**SEL_W,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] d_in,
  input  logic [ADDR_W-1:0] or_in,
  input  logic [COND_W-1:0] cond_in,
  input  logic [SEL_W-1:0]  cond_sel,
  input  logic              cond_pol,
  input  logic              cin,
  output logic [ADDR_W-1:0] addr_out,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_error,
  output logic              counter_zero,
  output logic [SP_W-1:0]   depth
);

  typedef enum logic [2:0] {
    OP_CONT = 3'd0,
    OP_JZ   = 3'd1,
    OP_CJP  = 3'd2,
    OP_CJS  = 3'd3,
    OP_CRTN = 3'd4,
    OP_PUSH = 3'd5,
    OP_RPCT = 3'd6,
    OP_LDCT = 3'd7
  } op_t;

  logic [ADDR_W-1:0] upc;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [CNT_W-1:0]  counter;

  logic              pass;
  logic              full;
  logic [IDX_W-1:0]  tos_idx;
  logic [ADDR_W-1:0] next_addr;
  logic              do_push;
  logic              do_pop;
  logic              under_err;
  logic              ld_cnt;
  logic              dec_cnt;
  logic              clr_stack;

  assign pass    = cond_in[cond_sel] ^ cond_pol;
  assign full    = (sp == SP_W'(STACK_DEPTH));
  // Only meaningful when sp > 0; the pop path is gated on that.
  assign tos_idx = IDX_W'(sp - SP_W'(1));

  // Next-address mux and per-op control strobes, decoded from op and current state.
  always_comb begin
    next_addr = upc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    under_err = 1'b0;
    ld_cnt    = 1'b0;
    dec_cnt   = 1'b0;
    clr_stack = 1'b0;
    case (op_t'(op))
      OP_CONT: next_addr = upc;
      OP_JZ: begin
        next_addr = '0;
        clr_stack = 1'b1;
      end
      OP_CJP: if (pass) next_addr = d_in | or_in;
      OP_CJS: begin
        if (pass) begin
          next_addr = d_in | or_in;
          do_push   = 1'b1;
        end
      end
      OP_CRTN: begin
        if (pass) begin
          if (sp != '0) begin
            next_addr = stack[tos_idx];
            do_pop    = 1'b1;
          end else begin
            under_err = 1'b1;
          end
        end
      end
      OP_PUSH: begin
        do_push = 1'b1;
        ld_cnt  = pass;
      end
      OP_RPCT: begin
        if (counter != '0) begin
          next_addr = d_in;
          dec_cnt   = 1'b1;
        end
      end
      OP_LDCT: ld_cnt = 1'b1;
      default: next_addr = upc;
    endcase
  end

  assign addr_out     = reset ? '0 : next_addr;
  assign stack_empty  = (sp == '0);
  assign stack_full   = full;
  assign counter_zero = (counter == '0);
  assign depth        = sp;

  // Control state: uPC, stack pointer, loop counter and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upc         <= '0;
      sp          <= '0;
      counter     <= '0;
      stack_error <= 1'b0;
    end else if (!hold) begin
      upc <= next_addr + ADDR_W'(cin);
      if (clr_stack) begin
        sp          <= '0;
        stack_error <= 1'b0;
      end else if (do_push) begin
        if (full) stack_error <= 1'b1;
        else      sp          <= sp + SP_W'(1);
      end else if (do_pop) begin
        sp <= sp - SP_W'(1);
      end else if (under_err) begin
        stack_error <= 1'b1;
      end
      if (ld_cnt)       counter <= d_in[CNT_W-1:0];
      else if (dec_cnt) counter <= counter - CNT_W'(1);
    end
  end

  // Return-stack storage; contents need no reset, the pointer guards validity.
  always_ff @(posedge clock) begin
    if (!reset && !hold && do_push && !full) stack[IDX_W'(sp)] <= upc;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with hand-computed address traces.
module tb_micro_sequencer;

  localparam logic [2:0] CONT = 3'd0, JZ = 3'd1, CJP = 3'd2, CJS = 3'd3,
                         CRTN = 3'd4, PUSH = 3'd5, RPCT = 3'd6, LDCT = 3'd7;

  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic [2:0]  op;
  logic [10:0] d_in;
  logic [10:0] or_in;
  logic [7:0]  cond_in;
  logic [2:0]  cond_sel;
  logic        cond_pol;
  logic        cin;
  logic [10:0] addr_out;
  logic        stack_empty;
  logic        stack_full;
  logic        stack_error;
  logic        counter_zero;
  logic [2:0]  depth;

  int tests  = 0;
  int failed = 0;

  micro_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .hold         (hold),
    .op           (op),
    .d_in         (d_in),
    .or_in        (or_in),
    .cond_in      (cond_in),
    .cond_sel     (cond_sel),
    .cond_pol     (cond_pol),
    .cin          (cin),
    .addr_out     (addr_out),
    .stack_empty  (stack_empty),
    .stack_full   (stack_full),
    .stack_error  (stack_error),
    .counter_zero (counter_zero),
    .depth        (depth)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input int d, input int m, input logic c);
    op    = o;
    d_in  = 11'(d);
    or_in = 11'(m);
    cin   = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hold = 1'b0; op = CONT; d_in = '0; or_in = '0;
    cond_in = 8'h01; cond_sel = 3'd0; cond_pol = 1'b0; cin = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_addr",  32'(addr_out), 0);
    chk("rst_empty", 32'(stack_empty), 1);
    chk("rst_full",  32'(stack_full), 0);
    chk("rst_err",   32'(stack_error), 0);
    chk("rst_cz",    32'(counter_zero), 1);
    chk("rst_depth", 32'(depth), 0);
    reset = 1'b0;

    // Sequential CONT, then reset mid-run
    for (int i = 0; i < 5; i++) begin
      drive(CONT, 0, 0, 1'b1);
      chk("cont_seq", 32'(addr_out), i);
      tick();
    end
    chk("cont_5", 32'(addr_out), 5);
    reset = 1'b1;
    #1;
    chk("midrst_addr", 32'(addr_out), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_restart0", 32'(addr_out), 0);
    tick();
    chk("rst_restart1", 32'(addr_out), 1);

    // Wrap at top of address space
    drive(CJP, 'h7FF, 0, 1'b0);
    chk("cjp_7ff", 32'(addr_out), 'h7FF);
    tick();
    drive(CONT, 0, 0, 1'b0);
    chk("hold_7ff_a", 32'(addr_out), 'h7FF);
    tick();
    chk("hold_7ff_b", 32'(addr_out), 'h7FF);
    drive(CONT, 0, 0, 1'b1);
    tick();
    chk("wrap_0", 32'(addr_out), 0);

    // CJS with OR mask, then return
    drive(CJP, 'h010, 0, 1'b0);
    tick();
    drive(CJS, 'h200, 'h003, 1'b1);
    chk("cjs_or", 32'(addr_out), 'h203);
    tick();
    chk("cjs_depth", 32'(depth), 1);
    drive(CONT, 0, 0, 1'b1);
    chk("after_cjs", 32'(addr_out), 'h204);
    tick();
    tick();
    drive(CRTN, 0, 0, 1'b1);
    chk("crtn_ret", 32'(addr_out), 'h010);
    tick();
    chk("crtn_depth", 32'(depth), 0);
    drive(CONT, 0, 0, 1'b1);
    chk("after_ret", 32'(addr_out), 'h011);

    // Overflow: five pushes into a four-deep stack
    for (int i = 0; i < 5; i++) begin
      drive(CJS, 'h100 + i * 'h10, 0, 1'b1);
      chk("ovf_addr", 32'(addr_out), 'h100 + i * 'h10);
      tick();
      chk("ovf_depth", 32'(depth), (i < 4) ? i + 1 : 4);
      chk("ovf_err", 32'(stack_error), (i == 4) ? 1 : 0);
    end
    chk("ovf_full", 32'(stack_full), 1);

    // LIFO unwind, then underflow
    drive(CRTN, 0, 0, 1'b1);
    chk("pop_0", 32'(addr_out), 'h121);
    tick();
    drive(CRTN, 0, 0, 1'b1);
    chk("pop_1", 32'(addr_out), 'h111);
    tick();
    drive(CRTN, 0, 0, 1'b1);
    chk("pop_2", 32'(addr_out), 'h101);
    tick();
    drive(CRTN, 0, 0, 1'b1);
    chk("pop_3", 32'(addr_out), 'h011);
    tick();
    chk("pop_empty", 32'(stack_empty), 1);
    drive(CRTN, 0, 0, 1'b1);
    chk("underflow_addr", 32'(addr_out), 'h012);
    tick();
    chk("underflow_depth", 32'(depth), 0);
    chk("underflow_err", 32'(stack_error), 1);
    drive(JZ, 'h123, 0, 1'b1);
    chk("jz_addr", 32'(addr_out), 0);
    tick();
    chk("jz_err", 32'(stack_error), 0);
    chk("jz_depth", 32'(depth), 0);

    // Loop counter
    drive(LDCT, 3, 0, 1'b1);
    chk("ldct_addr", 32'(addr_out), 1);
    tick();
    chk("ldct_cz", 32'(counter_zero), 0);
    for (int i = 0; i < 3; i++) begin
      drive(RPCT, 'h050, 0, 1'b1);
      chk("rpct_br", 32'(addr_out), 'h050);
      tick();
      chk("rpct_cz", 32'(counter_zero), (i == 2) ? 1 : 0);
    end
    drive(RPCT, 'h050, 0, 1'b1);
    chk("rpct_fall", 32'(addr_out), 'h051);
    tick();
    chk("rpct_cz_end", 32'(counter_zero), 1);

    // Condition select and polarity
    cond_sel = 3'd2; cond_in = 8'h04; cond_pol = 1'b0;
    drive(CJP, 'h300, 0, 1'b1);
    chk("cond_take", 32'(addr_out), 'h300);
    cond_pol = 1'b1;
    #1;
    chk("cond_inv", 32'(addr_out), 'h052);
    cond_pol = 1'b0; cond_sel = 3'd1;
    #1;
    chk("cond_sel1", 32'(addr_out), 'h052);
    cond_sel = 3'd2;

    // Hold freezes state while addr_out still follows op
    drive(LDCT, 5, 0, 1'b1);
    tick();
    hold = 1'b1;
    drive(CJS, 'h222, 0, 1'b1);
    chk("hold_addr", 32'(addr_out), 'h222);
    tick();
    hold = 1'b0;
    drive(CONT, 0, 0, 1'b1);
    chk("hold_upc", 32'(addr_out), 'h053);
    chk("hold_depth", 32'(depth), 0);
    chk("hold_cz", 32'(counter_zero), 0);
    tick();

    // PUSH loads counter and saves loop head
    drive(PUSH, 2, 0, 1'b1);
    chk("push_addr", 32'(addr_out), 'h054);
    tick();
    chk("push_depth", 32'(depth), 1);
    drive(RPCT, 'h060, 0, 1'b1);
    chk("push_rpct1", 32'(addr_out), 'h060);
    tick();
    drive(RPCT, 'h060, 0, 1'b1);
    chk("push_rpct2", 32'(addr_out), 'h060);
    tick();
    chk("push_cz", 32'(counter_zero), 1);
    drive(CRTN, 0, 0, 1'b1);
    chk("push_ret", 32'(addr_out), 'h054);
    tick();
    chk("push_pop_depth", 32'(depth), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
